// File: rtl/dmem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_bus_ctrl
//
// Purpose:
//   Data-side bus master sitting directly after the MEM stage. Each MEM-stage
//   memory request is run as one request/ack transfer on a wishbone-style bus.
//   The full 32-bit read word is handed back to the MEM stage (which does the
//   byte-lane extraction itself). While a transfer is outstanding the block
//   raises a stall request to pipeline control. A transfer is abandoned on a
//   pipeline flush or when the bus fails to acknowledge within TIMEOUT_CYC
//   cycles.
//
// Parameters:
//   TIMEOUT_CYC  maximum BUSY cycles waiting for bus_ack_i (8-bit counter);
//                0 disables the timeout.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cpu_ce_i/we_i       request valid / write flag from the MEM stage
//   cpu_addr_i/sel_i    word address and byte-lane enables (bit 3 = [31:24])
//   cpu_data_i          lane-replicated write data
//   cpu_data_o          read word returned to the MEM stage
//   stallreq_o          stall request to pipeline control
//   stall_i, flush_i    pipeline held by another source / pipeline flush
//   err_o               one-cycle pulse when a transfer is aborted on timeout
//   bus_*_o             registered bus request (cyc, stb, we, addr, sel, data)
//   bus_data_i/ack_i    bus read data and acknowledge
// -----------------------------------------------------------------------------
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        err_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] TO_LIM = TIMEOUT_CYC[7:0];
  localparam logic       TO_EN  = (TIMEOUT_CYC != 32'd0) ? 1'b1 : 1'b0;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        req_s;
  logic        busy_s;
  logic        ack_s;
  logic        tmo_s;
  logic        done_s;
  logic [31:0] done_data_s;

  // A new request is only accepted when it is not being flushed away.
  assign req_s  = cpu_ce_i & ~flush_i;
  assign busy_s = (state_q == ST_BUSY);

  // Completion terms in BUSY; flush beats ack, ack beats timeout.
  assign ack_s  = busy_s & ~flush_i & bus_ack_i;
  assign tmo_s  = busy_s & ~flush_i & ~bus_ack_i & TO_EN & (cnt_q == TO_LIM);
  assign done_s = ack_s | tmo_s;

  // Word handed back on completion: a timeout returns 0, and so does a write.
  assign done_data_s = (ack_s & ~we_q) ? bus_data_i : 32'd0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (done_s) begin
          // Park in WAIT while the pipeline is frozen so the still-present
          // request is not issued a second time.
          state_d = stall_i ? ST_WAIT : ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_WAIT: begin
        if (~stall_i | flush_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Combinational outputs to the MEM stage: stall request and read word.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = 32'd0;
    case (state_q)
      ST_IDLE: begin
        stallreq_o = req_s;
        cpu_data_o = 32'd0;
      end
      ST_BUSY: begin
        stallreq_o = ~flush_i & ~done_s;
        if (done_s) begin
          cpu_data_o = done_data_s;
        end else begin
          cpu_data_o = 32'd0;
        end
      end
      ST_WAIT: begin
        stallreq_o = 1'b0;
        cpu_data_o = rd_buf_q;
      end
      default: begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'd0;
      end
    endcase
  end

  // Next values of the bus request, read buffer, timeout counter and error.
  always_comb begin
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    rd_buf_d = rd_buf_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          // The latched copy is authoritative for the whole transfer.
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = cpu_we_i;
          addr_d  = cpu_addr_i;
          sel_d   = cpu_sel_i;
          wdata_d = cpu_data_i;
          cnt_d   = 8'd0;
        end else begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          // Abandon the transfer; any same-cycle ack and its data are dropped.
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
        end else if (done_s) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          rd_buf_d = done_data_s;
          err_d    = tmo_s;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WAIT: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
      default: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        we_d  = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops cyc/stb at once, mid-transfer included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      sel_q    <= 4'd0;
      wdata_q  <= 32'd0;
      rd_buf_q <= 32'd0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      rd_buf_q <= rd_buf_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus_cyc_o  = cyc_q;
  assign bus_stb_o  = stb_q;
  assign bus_we_o   = we_q;
  assign bus_addr_o = addr_q;
  assign bus_sel_o  = sel_q;
  assign bus_data_o = wdata_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_ctrl
//
// Self-checking bench for dmem_bus_ctrl (built with TIMEOUT_CYC = 4).
// Transactions are described at the level of the bus protocol: how many BUSY
// cycles the slave takes before acking, and how many cycles the pipeline stays
// frozen after completion. The expected per-cycle view is computed from those
// numbers (stall request high until completion, timeout beats a late ack,
// read word only on completion and while frozen, error one cycle later).
// -----------------------------------------------------------------------------
module tb_dmem_bus_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        stall_i;
  logic        flush_i;
  logic        err_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;

  int   pass_cnt;
  int   tot_cnt;
  logic exp_err;

  dmem_bus_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .err_o      (err_o),
    .bus_cyc_o  (bus_cyc_o),
    .bus_stb_o  (bus_stb_o),
    .bus_we_o   (bus_we_o),
    .bus_addr_o (bus_addr_o),
    .bus_sel_o  (bus_sel_o),
    .bus_data_o (bus_data_o),
    .bus_data_i (bus_data_i),
    .bus_ack_i  (bus_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete access. wait_n = BUSY cycles before the slave acks,
  // stall_n = cycles the pipeline stays frozen after completion.
  task automatic run_xfer(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          input logic [31:0] rd, input int wait_n, input int stall_n,
                          input bit idle_after);
    bit           to;
    int           done_i;
    logic [31:0]  exp_rd;
    logic [35:0]  obs_s;
    logic [35:0]  exp_s;
    logic [104:0] obs_b;
    logic [104:0] exp_b;
    to     = (TO != 0) && (wait_n > TO);
    done_i = to ? TO : wait_n;
    exp_rd = (to || we) ? 32'd0 : rd;
    // request cycle in IDLE
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wd;
    stall_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0; bus_data_i = rd;
    #2;
    obs_s = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, cpu_data_o};
    exp_s = {1'b1, 1'b0, 1'b0, exp_err, 32'd0};
    tot_cnt++;
    if (obs_s !== exp_s) $display("FAIL %s req: got %h want %h", tag, obs_s, exp_s);
    else pass_cnt++;
    exp_err = 1'b0;
    next_cycle();
    // BUSY cycles; the pipeline-side inputs are scrambled to prove the latch holds
    for (int i = 0; i <= done_i; i++) begin
      bus_ack_i  = (i == wait_n);
      stall_i    = (i == done_i) && (stall_n > 0);
      cpu_addr_i = $urandom;
      cpu_data_i = $urandom;
      #2;
      obs_b = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, bus_we_o, bus_sel_o,
               cpu_data_o, bus_addr_o, bus_data_o};
      exp_b = {(i != done_i), 1'b1, 1'b1, 1'b0, we, sel,
               ((i == done_i) ? exp_rd : 32'd0), addr, wd};
      tot_cnt++;
      if (obs_b !== exp_b) $display("FAIL %s busy%0d: got %h want %h", tag, i, obs_b, exp_b);
      else pass_cnt++;
      next_cycle();
    end
    bus_ack_i = 1'b0;
    exp_err   = to;
    // frozen pipeline: read word held, no re-issue of the still-present request
    for (int k = 0; k < stall_n; k++) begin
      stall_i    = (k < stall_n - 1);
      bus_data_i = $urandom;
      #2;
      obs_s = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, cpu_data_o};
      exp_s = {1'b0, 1'b0, 1'b0, exp_err, exp_rd};
      tot_cnt++;
      if (obs_s !== exp_s) $display("FAIL %s wait%0d: got %h want %h", tag, k, obs_s, exp_s);
      else pass_cnt++;
      exp_err = 1'b0;
      next_cycle();
    end
    stall_i = 1'b0;
    if (idle_after) begin
      cpu_ce_i = 1'b0;
      #2;
      obs_s = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, cpu_data_o};
      exp_s = {1'b0, 1'b0, 1'b0, exp_err, 32'd0};
      tot_cnt++;
      if (obs_s !== exp_s) $display("FAIL %s idle: got %h want %h", tag, obs_s, exp_s);
      else pass_cnt++;
      exp_err = 1'b0;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    logic [104:0] obs_b;
    #3;
    obs_b = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, bus_we_o, bus_sel_o,
             cpu_data_o, bus_addr_o, bus_data_o};
    tot_cnt++;
    if (obs_b !== 105'd0) $display("FAIL reset_state: got %h want 0", obs_b);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_read_wait();
    run_xfer("read_wait3", 1'b0, 32'h0000_0104, 4'b1111, 32'h0, 32'hDEADBEEF, 3, 0, 1'b1);
  endtask

  task automatic test_byte_write();
    run_xfer("byte_write", 1'b1, 32'h0000_0203, 4'b0001, 32'h5A5A5A5A, 32'hCAFEF00D, 1, 0, 1'b1);
  endtask

  task automatic test_ack_stall();
    run_xfer("ack_stall", 1'b0, 32'h0000_0040, 4'b1111, 32'h0, 32'h12345678, 1, 3, 1'b1);
  endtask

  task automatic test_flush();
    logic [35:0] obs_s;
    // flush together with ack in the second BUSY cycle
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300; cpu_sel_i = 4'hF;
    flush_i = 1'b0; stall_i = 1'b0; bus_ack_i = 1'b0; bus_data_i = 32'hA5A5A5A5;
    next_cycle();
    next_cycle();
    bus_ack_i = 1'b1; flush_i = 1'b1;
    #2;
    obs_s = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, cpu_data_o};
    tot_cnt++;
    if (obs_s !== {4'b0110, 32'd0}) $display("FAIL flush_ack: got %h want %h", obs_s, {4'b0110, 32'd0});
    else pass_cnt++;
    next_cycle();
    bus_ack_i = 1'b0; flush_i = 1'b0; cpu_ce_i = 1'b0;
    #2;
    obs_s = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, cpu_data_o};
    tot_cnt++;
    if (obs_s !== 36'd0) $display("FAIL flush_after: got %h want 0", obs_s);
    else pass_cnt++;
    next_cycle();
    // a request under flush in IDLE is not taken
    cpu_ce_i = 1'b1; flush_i = 1'b1;
    #2;
    tot_cnt++;
    if (stallreq_o !== 1'b0) $display("FAIL flush_idle_req: got %b want 0", stallreq_o);
    else pass_cnt++;
    next_cycle();
    cpu_ce_i = 1'b0; flush_i = 1'b0;
    #2;
    tot_cnt++;
    if ({bus_cyc_o, bus_stb_o} !== 2'b00) $display("FAIL flush_idle_bus: got %b want 00", {bus_cyc_o, bus_stb_o});
    else pass_cnt++;
    next_cycle();
    // flush releases WAIT even while stall_i is still high
    cpu_ce_i = 1'b1; bus_data_i = 32'h0BADCAFE;
    next_cycle();
    bus_ack_i = 1'b1; stall_i = 1'b1;
    next_cycle();
    bus_ack_i = 1'b0; flush_i = 1'b1;
    #2;
    obs_s = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, cpu_data_o};
    tot_cnt++;
    if (obs_s !== {4'b0000, 32'h0BADCAFE}) $display("FAIL flush_wait_hold: got %h want %h", obs_s, {4'b0000, 32'h0BADCAFE});
    else pass_cnt++;
    next_cycle();
    flush_i = 1'b0; cpu_ce_i = 1'b0;
    #2;
    tot_cnt++;
    if (cpu_data_o !== 32'd0) $display("FAIL flush_wait_exit: got %h want 0", cpu_data_o);
    else pass_cnt++;
    next_cycle();
    stall_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_timeout();
    run_xfer("timeout", 1'b0, 32'h0000_0600, 4'b1111, 32'h0, 32'h11111111, 50, 0, 1'b1);
    run_xfer("ack_at_limit", 1'b0, 32'h0000_0604, 4'b1111, 32'h0, 32'h22222222, TO, 0, 1'b1);
    run_xfer("timeout_stall", 1'b0, 32'h0000_0608, 4'b1111, 32'h0, 32'h33333333, TO + 1, 2, 1'b1);
  endtask

  task automatic test_sel_zero();
    run_xfer("sel_zero", 1'b1, 32'h0000_0701, 4'b0000, 32'h77777777, 32'h0, 0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_xfer("b2b_a", 1'b0, 32'h0000_0800, 4'b1111, 32'h0, 32'hAAAA0001, 0, 0, 1'b0);
    run_xfer("b2b_b", 1'b1, 32'h0000_0804, 4'b1100, 32'hBBBB0002, 32'h0, 2, 0, 1'b0);
    run_xfer("b2b_c", 1'b0, 32'h0000_0808, 4'b0011, 32'h0, 32'hCCCC0003, 1, 2, 1'b0);
    run_xfer("b2b_d", 1'b0, 32'h0000_080C, 4'b1111, 32'h0, 32'hDDDD0004, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_xfer("random", 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
               $urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end
    cpu_ce_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_async_reset();
    logic [104:0] obs_b;
    logic [35:0]  obs_s;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h500; cpu_sel_i = 4'hF;
    cpu_data_i = 32'h55AA55AA; bus_ack_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    next_cycle();
    #2;
    tot_cnt++;
    if ({bus_cyc_o, bus_stb_o} !== 2'b11) $display("FAIL rst_pre_busy: got %b want 11", {bus_cyc_o, bus_stb_o});
    else pass_cnt++;
    // assert reset away from any clock edge
    rst = 1'b1; cpu_ce_i = 1'b0;
    #1;
    obs_b = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, bus_we_o, bus_sel_o,
             cpu_data_o, bus_addr_o, bus_data_o};
    tot_cnt++;
    if (obs_b !== 105'd0) $display("FAIL rst_async: got %h want 0", obs_b);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    // late ack from the aborted transfer must be ignored
    bus_ack_i = 1'b1; bus_data_i = 32'hFEEDFACE;
    next_cycle();
    #2;
    obs_s = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, cpu_data_o};
    tot_cnt++;
    if (obs_s !== 36'd0) $display("FAIL rst_late_ack: got %h want 0", obs_s);
    else pass_cnt++;
    next_cycle();
    bus_ack_i = 1'b0;
    #2;
    obs_s = {stallreq_o, bus_cyc_o, bus_stb_o, err_o, cpu_data_o};
    tot_cnt++;
    if (obs_s !== 36'd0) $display("FAIL rst_idle: got %h want 0", obs_s);
    else pass_cnt++;
    next_cycle();
  endtask

  initial begin
    pass_cnt = 0; tot_cnt = 0; exp_err = 1'b0;
    rst = 1'b1;
    cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'd0; cpu_sel_i = 4'd0;
    cpu_data_i = 32'd0; stall_i = 1'b0; flush_i = 1'b0;
    bus_data_i = 32'd0; bus_ack_i = 1'b0;
    test_reset();
    test_read_wait();
    test_byte_write();
    test_ack_stall();
    test_flush();
    test_timeout();
    test_sel_zero();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
